// File: rtl/lfsr_checker_if.sv
// Stream/status bundle between a bit source (master) and the x^4+x+1 PRNG checker (slave).
interface lfsr_checker_if #(
    parameter int CNT_W = 16
) ();
    logic             i_valid;
    logic             i_bit;
    logic             i_clr_cnt;
    logic             o_locked;
    logic             o_err;
    logic [CNT_W-1:0] o_err_cnt;
    logic [3:0]       o_window;

    modport master (
        output i_valid, i_bit, i_clr_cnt,
        input  o_locked, o_err, o_err_cnt, o_window
    );

    modport slave (
        input  i_valid, i_bit, i_clr_cnt,
        output o_locked, o_err, o_err_cnt, o_window
    );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 4-bit right-shifting x^4+x+1 PRNG stream:
// hunts for alignment, verifies, then flywheels and counts bit errors while locked.
module lfsr_checker #(
    parameter int LOCK_CNT    = 8,
    parameter int UNLOCK_ERRS = 3,
    parameter int CNT_W       = 16
) (
    input  logic          clk,
    input  logic          rst,
    lfsr_checker_if.slave bus
);
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;

    localparam logic [7:0]       LOCK_B   = 8'(LOCK_CNT);
    localparam logic [7:0]       UNLOCK_B = 8'(UNLOCK_ERRS);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e           state_q, state_d;
    logic [3:0]       win_q, win_d;
    logic [2:0]       fill_q, fill_d;
    logic [7:0]       good_q, good_d;
    logic [7:0]       cerr_q, cerr_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pred;
    logic             hit;

    // NOTE: sequential state uses <= only; the comb blocks below use = so
    // later statements can read values computed earlier in the same pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            win_q   <= '0;
            fill_q  <= '0;
            good_q  <= '0;
            cerr_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            good_q  <= good_d;
            cerr_q  <= cerr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Recurrence b[n+4] = b[n+1] ^ b[n] applied to the current window.
    assign pred = win_q[1] ^ win_q[0];
    assign hit  = (bus.i_bit == pred);

    // NOTE: every comb output gets a hold default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        fill_d  = fill_q;
        good_d  = good_q;
        cerr_d  = cerr_q;
        err_d   = 1'b0;
        if (bus.i_valid) begin
            case (state_q)
                HUNT: begin
                    win_d = {bus.i_bit, win_q[3:1]};
                    if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
                    // An all-zero window is the LFSR lock-up state and can never be valid.
                    if (fill_d == 3'd4 && win_d != 4'b0000) begin
                        state_d = VERIFY;
                        good_d  = '0;
                    end
                end
                VERIFY: begin
                    win_d = {bus.i_bit, win_q[3:1]};
                    if (hit) begin
                        good_d = good_q + 8'd1;
                        if (good_d == LOCK_B) begin
                            state_d = LOCKED;
                            cerr_d  = '0;
                        end
                    end else begin
                        fill_d  = 3'd4;
                        good_d  = '0;
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    // Flywheel: the window follows the prediction, so line errors do not corrupt it.
                    win_d = {pred, win_q[3:1]};
                    if (hit) begin
                        cerr_d = '0;
                    end else begin
                        err_d  = 1'b1;
                        cerr_d = cerr_q + 8'd1;
                        if (cerr_d == UNLOCK_B) begin
                            state_d = HUNT;
                            fill_d  = '0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.i_clr_cnt) begin
            cnt_d = err_d ? CNT_W'(1) : '0;
        end else if (err_d && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        bus.o_locked  = (state_q == LOCKED);
        bus.o_err     = err_q;
        bus.o_err_cnt = cnt_q;
        bus.o_window  = win_q;
    end
endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a 16-bit-counter and a 2-bit-counter instance share one stimulus stream.
module tb_lfsr_checker;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lfsr_checker_if #(.CNT_W(16)) bus_a ();
    lfsr_checker_if #(.CNT_W(2))  bus_b ();

    lfsr_checker #(.LOCK_CNT(8), .UNLOCK_ERRS(3), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    lfsr_checker #(.LOCK_CNT(8), .UNLOCK_ERRS(3), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int         n_vec = 0;
    int         n_bad = 0;
    int         err_a = 0;
    int         lk_a  = 0;
    logic [3:0] gen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive both instances, wait one clock, sample on the falling edge.
    task automatic apply(input logic v, input logic b, input logic clr = 1'b0);
        bus_a.i_valid   = v;
        bus_a.i_bit     = b;
        bus_a.i_clr_cnt = clr;
        bus_b.i_valid   = v;
        bus_b.i_bit     = b;
        bus_b.i_clr_cnt = clr;
        @(negedge clk);
        if (bus_a.o_err)    err_a++;
        if (bus_a.o_locked) lk_a++;
    endtask

    // Valid cycles carry the generator bit; idle cycles carry its complement to prove it is ignored.
    task automatic send_gen(input logic v, input logic clr = 1'b0);
        if (v) begin
            apply(1'b1, gen[0], clr);
            gen = {gen[1] ^ gen[0], gen[3:1]};
        end else begin
            apply(1'b0, ~gen[0], clr);
        end
    endtask

    task automatic send_bad(input logic clr = 1'b0);
        apply(1'b1, ~gen[0], clr);
        gen = {gen[1] ^ gen[0], gen[3:1]};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(1'b1, ~gen[0]);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        gen = 4'b1011;
        apply(1'b0, 1'b0);
        do_reset();
        check("rst_locked", bus_a.o_locked,  0);
        check("rst_err",    bus_a.o_err,     0);
        check("rst_cnt",    bus_a.o_err_cnt, 0);
        check("rst_window", bus_a.o_window,  0);
        check("rst_cnt_b",  bus_b.o_err_cnt, 0);

        // Clean continuous stream from seed 1011.
        gen = 4'b1011;
        repeat (4) send_gen(1'b1);
        check("fill_window", bus_a.o_window, 4'b1011);
        check("fill_locked", bus_a.o_locked, 0);
        repeat (7) send_gen(1'b1);
        check("bit11_locked", bus_a.o_locked, 0);
        send_gen(1'b1);
        check("bit12_locked", bus_a.o_locked, 1);
        check("bit12_window", bus_a.o_window, 4'b0001);
        err_a = 0;
        repeat (88) send_gen(1'b1);
        check("clean_errs",   err_a,           0);
        check("clean_locked", bus_a.o_locked,  1);
        check("bit100_win",   bus_a.o_window,  4'b0111);
        check("clean_cnt",    bus_a.o_err_cnt, 0);

        // One inverted bit while locked.
        err_a = 0;
        send_bad();
        check("single_err",    bus_a.o_err,     1);
        check("single_cnt",    bus_a.o_err_cnt, 1);
        check("single_locked", bus_a.o_locked,  1);
        send_gen(1'b1);
        check("single_err_off", bus_a.o_err, 0);
        repeat (10) send_gen(1'b1);
        check("single_total",  err_a,           1);
        check("single_cnt2",   bus_a.o_err_cnt, 1);
        check("flywheel_win",  bus_a.o_window,  4'b1101);

        // Clear, then three consecutive errors drop lock.
        send_gen(1'b1, 1'b1);
        check("clr_cnt", bus_a.o_err_cnt, 0);
        send_bad();
        check("burst1_err", bus_a.o_err, 1);
        check("burst1_lk",  bus_a.o_locked, 1);
        send_bad();
        check("burst2_err", bus_a.o_err, 1);
        check("burst2_cnt", bus_a.o_err_cnt, 2);
        send_bad();
        check("burst3_err", bus_a.o_err, 1);
        check("burst3_cnt", bus_a.o_err_cnt, 3);
        check("burst3_lk",  bus_a.o_locked, 0);
        err_a = 0;
        repeat (11) send_gen(1'b1);
        check("relock11", bus_a.o_locked, 0);
        send_gen(1'b1);
        check("relock12",      bus_a.o_locked,  1);
        check("relock_noerr",  err_a,           0);
        check("relock_cnt",    bus_a.o_err_cnt, 3);

        // Alternating valid/idle: lock point counted in valid bits only.
        do_reset();
        gen = 4'b1011;
        for (int i = 1; i <= 12; i++) begin
            send_gen(1'b1);
            if (i == 4)  check("tog_fill_win", bus_a.o_window, 4'b1011);
            if (i == 12) check("tog_lock",     bus_a.o_locked, 1);
            if (i == 12) check("tog_lock_win", bus_a.o_window, 4'b0001);
            send_gen(1'b0);
            if (i == 4)  check("tog_hold_win", bus_a.o_window, 4'b1011);
            if (i == 11) check("tog_11_lk",    bus_a.o_locked, 0);
            if (i == 12) check("tog_hold_lk",  bus_a.o_locked, 1);
            if (i == 12) check("tog_hold_err", bus_a.o_err,    0);
            if (i == 12) check("tog_hold_w",   bus_a.o_window, 4'b0001);
        end

        // All-zero input never leaves HUNT.
        do_reset();
        err_a = 0;
        lk_a  = 0;
        repeat (50) apply(1'b1, 1'b0);
        check("zero_locked", lk_a,           0);
        check("zero_errs",   err_a,          0);
        check("zero_window", bus_a.o_window, 0);

        // Bit 7 flipped during VERIFY: realigns and locks after bit 19.
        do_reset();
        gen = 4'b1011;
        repeat (6) send_gen(1'b1);
        send_bad();
        repeat (11) send_gen(1'b1);
        check("vmis_18_lk", bus_a.o_locked, 0);
        send_gen(1'b1);
        check("vmis_19_lk",  bus_a.o_locked, 1);
        check("vmis_19_win", bus_a.o_window, 4'b1011);

        // Isolated errors: 2-bit counter saturates at 3, 16-bit one keeps counting.
        for (int k = 1; k <= 5; k++) begin
            send_bad();
            check("sat_err_b", bus_b.o_err,     1);
            check("sat_cnt_b", bus_b.o_err_cnt, (k < 3) ? k : 3);
            repeat (3) send_gen(1'b1);
        end
        check("sat_cnt_a",  bus_a.o_err_cnt, 5);
        check("sat_lock_b", bus_b.o_locked,  1);
        send_bad(1'b1);
        check("clr_err_cnt_b", bus_b.o_err_cnt, 1);
        check("clr_err_cnt_a", bus_a.o_err_cnt, 1);
        check("clr_err_b",     bus_b.o_err,     1);

        // Reset mid-lock with an offending valid bit present.
        rst = 1'b1;
        send_bad();
        rst = 1'b0;
        check("mrst_locked", bus_b.o_locked,  0);
        check("mrst_err",    bus_b.o_err,     0);
        check("mrst_cnt",    bus_b.o_err_cnt, 0);
        check("mrst_window", bus_b.o_window,  0);
        repeat (11) send_gen(1'b1);
        check("mrst_relock11", bus_b.o_locked, 0);
        send_gen(1'b1);
        check("mrst_relock12", bus_b.o_locked, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
